aes_round_sequencer: RTL and testbench

Control FSM that drives the one-round feedback cipher datapath through a complete AES-128 encryption.
- Accepts a 128-bit plaintext with a start/busy/done handshake.
- Fetches the 44 expanded round-key words from an external synchronous key store.
- Performs the round-0 AddRoundKey itself, then sequences rounds 1..NROUNDS on the datapath.
- Captures the ciphertext and pulses done.
- Sits between the host/bus interface and the feedback cipher core; it is the only driver of the core's round, key_flag and k1..k4 inputs.

---
 rtl/aes_round_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Control FSM that walks the one-round feedback AES datapath through a full
// AES-128 encryption: fetches four round-key words per round from a
// synchronous key store, performs the round-0 whitening locally, fires
// rounds 1..NROUNDS on the datapath and captures the ciphertext.
//
// Optional build macro: AES_SEQ_ABORT_EN adds an 'abort' input that returns
// the sequencer to IDLE from any active state without a done pulse.
module aes_round_sequencer #(
    parameter int NROUNDS  = 10,
    parameter int KEY_BASE = 0,
    parameter int AW       = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef AES_SEQ_ABORT_EN
    input  logic          abort,
`endif
    input  logic [31:0]   pt0,
    input  logic [31:0]   pt1,
    input  logic [31:0]   pt2,
    input  logic [31:0]   pt3,
    output logic          busy,
    output logic          done,
    output logic [31:0]   ct0,
    output logic [31:0]   ct1,
    output logic [31:0]   ct2,
    output logic [31:0]   ct3,
    output logic [AW-1:0] key_addr,
    output logic          key_rd,
    input  logic [31:0]   key_rdata,
    output logic [31:0]   dp_a,
    output logic [31:0]   dp_b,
    output logic [31:0]   dp_c,
    output logic [31:0]   dp_d,
    output logic [31:0]   dp_k1,
    output logic [31:0]   dp_k2,
    output logic [31:0]   dp_k3,
    output logic [31:0]   dp_k4,
    output logic [3:0]    dp_round,
    output logic          dp_key_flag,
    input  logic [31:0]   dp_x,
    input  logic [31:0]   dp_y,
    input  logic [31:0]   dp_z,
    input  logic [31:0]   dp_w
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_WHITEN,
        S_FIRE,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] KB       = AW'(KEY_BASE);
    localparam logic [3:0]    LAST_RND = 4'(NROUNDS);

    state_t      fsm;
    logic [3:0]  rnd;
    logic [1:0]  word_idx;
    logic [31:0] st_w [4];
    logic [31:0] kreg [4];
    logic        abort_req;

`ifdef AES_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Round-key word r*4+w lives at KEY_BASE + 4*r + w (unsigned, AW bits).
    function automatic logic [AW-1:0] key_word_addr(input logic [3:0] r,
                                                     input logic [1:0] wi);
        return KB + AW'({r, wi});
    endfunction

    // Key registers drive the datapath key inputs directly so they stay
    // stable from the end of the fetch burst through the FIRE cycle.
    assign dp_k1 = kreg[0];
    assign dp_k2 = kreg[1];
    assign dp_k3 = kreg[2];
    assign dp_k4 = kreg[3];

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= S_IDLE;
            rnd         <= 4'd0;
            word_idx    <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            key_rd      <= 1'b0;
            key_addr    <= '0;
            dp_key_flag <= 1'b0;
            dp_round    <= 4'd0;
            dp_a        <= '0;
            dp_b        <= '0;
            dp_c        <= '0;
            dp_d        <= '0;
            ct0         <= '0;
            ct1         <= '0;
            ct2         <= '0;
            ct3         <= '0;
            for (int i = 0; i < 4; i++) begin
                st_w[i] <= '0;
                kreg[i] <= '0;
            end
        end else begin
            done        <= 1'b0;
            dp_key_flag <= 1'b0;
            if (abort_req && fsm != S_IDLE) begin
                fsm    <= S_IDLE;
                busy   <= 1'b0;
                key_rd <= 1'b0;
            end else begin
                case (fsm)
                    S_IDLE, S_DONE: begin
                        busy <= 1'b0;
                        fsm  <= S_IDLE;
                        if (start) begin
                            st_w[0]  <= pt0;
                            st_w[1]  <= pt1;
                            st_w[2]  <= pt2;
                            st_w[3]  <= pt3;
                            rnd      <= 4'd0;
                            word_idx <= 2'd0;
                            dp_round <= 4'd0;
                            key_addr <= key_word_addr(4'd0, 2'd0);
                            key_rd   <= 1'b1;
                            busy     <= 1'b1;
                            fsm      <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // Read data lags the address by one cycle.
                        if (word_idx != 2'd0) begin
                            kreg[word_idx - 2'd1] <= key_rdata;
                        end
                        if (word_idx == 2'd3) begin
                            key_rd <= 1'b0;
                            fsm    <= S_LAST;
                        end else begin
                            word_idx <= word_idx + 2'd1;
                            key_addr <= key_word_addr(rnd, word_idx + 2'd1);
                        end
                    end
                    S_LAST: begin
                        kreg[3] <= key_rdata;
                        if (rnd == 4'd0) begin
                            // Round 0 AddRoundKey; the fourth word bypasses kreg.
                            dp_a <= st_w[0] ^ kreg[0];
                            dp_b <= st_w[1] ^ kreg[1];
                            dp_c <= st_w[2] ^ kreg[2];
                            dp_d <= st_w[3] ^ key_rdata;
                            fsm  <= S_WHITEN;
                        end else begin
                            dp_key_flag <= 1'b1;
                            dp_round    <= rnd;
                            fsm         <= S_FIRE;
                        end
                    end
                    S_WHITEN: begin
                        rnd      <= 4'd1;
                        word_idx <= 2'd0;
                        key_addr <= key_word_addr(4'd1, 2'd0);
                        key_rd   <= 1'b1;
                        fsm      <= S_FETCH;
                    end
                    S_FIRE: begin
                        if (rnd != LAST_RND) begin
                            rnd      <= rnd + 4'd1;
                            word_idx <= 2'd0;
                            key_addr <= key_word_addr(rnd + 4'd1, 2'd0);
                            key_rd   <= 1'b1;
                            fsm      <= S_FETCH;
                        end else begin
                            // Final round output is combinational from the datapath.
                            ct0  <= dp_x;
                            ct1  <= dp_y;
                            ct2  <= dp_z;
                            ct3  <= dp_w;
                            done <= 1'b1;
                            busy <= 1'b0;
                            fsm  <= S_DONE;
                        end
                    end
                    default: begin
                        fsm <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Testbench for aes_round_sequencer: synchronous key store and a one-round
// feedback AES datapath around the DUT, with a full AES-128 reference model.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, busy, done, key_rd, dp_key_flag;
    logic [31:0] pt0, pt1, pt2, pt3, ct0, ct1, ct2, ct3, key_rdata;
    logic [5:0]  key_addr;
    logic [31:0] dp_a, dp_b, dp_c, dp_d, dp_k1, dp_k2, dp_k3, dp_k4;
    logic [31:0] dp_x, dp_y, dp_z, dp_w;
    logic [3:0]  dp_round;
`ifdef AES_SEQ_ABORT_EN
    logic        abort;
`endif

    aes_round_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef AES_SEQ_ABORT_EN
        .abort(abort),
`endif
        .pt0(pt0), .pt1(pt1), .pt2(pt2), .pt3(pt3),
        .busy(busy), .done(done),
        .ct0(ct0), .ct1(ct1), .ct2(ct2), .ct3(ct3),
        .key_addr(key_addr), .key_rd(key_rd), .key_rdata(key_rdata),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_k1(dp_k1), .dp_k2(dp_k2), .dp_k3(dp_k3), .dp_k4(dp_k4),
        .dp_round(dp_round), .dp_key_flag(dp_key_flag),
        .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z), .dp_w(dp_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_t [256];
    logic [31:0]  kmem [64];
    logic [127:0] fb, din, dp_out, ct_all;
    logic [5:0]   addr_q [$];
    logic [3:0]   rnd_q [$];
    int           busy_cnt;
    logic [127:0] whiten_s;

    localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] FIPS_PT  = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] FIPS_CT  = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;

    assign ct_all = {ct3, ct2, ct1, ct0};

    // ---------------- AES helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    // One AES round on column-packed state (byte r of column c at bit 32c+8r).
    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input bit last);
        logic [7:0] b [4][4];
        logic [7:0] t [4][4];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[c][r] = sbox_t[s[32*c+8*r +: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[c][r] = b[(c+r)%4][r];
        for (int c = 0; c < 4; c++) begin
            a0 = t[c][0]; a1 = t[c][1]; a2 = t[c][2]; a3 = t[c][3];
            if (!last) begin
                t[c][0] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[c][1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[c][2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[c][3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
            for (int r = 0; r < 4; r++) o[32*c+8*r +: 8] = t[c][r];
        end
        return o ^ k;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [1407:0] s;
        logic [31:0]   t;
        logic [7:0]    rc;
        s = '0;
        s[127:0] = key;
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = s[32*(i-1) +: 32];
            if (i % 4 == 0) begin
                t  = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rc};
                rc = xt(rc);
            end
            s[32*i +: 32] = s[32*(i-4) +: 32] ^ t;
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key,
                                                 input logic [127:0] pt);
        logic [1407:0] sch;
        logic [127:0]  s;
        sch = expand(key);
        s = pt ^ sch[127:0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, sch[128*r +: 128], r == 10);
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- environment ----------------
    always @(posedge clk) if (key_rd) key_rdata <= kmem[key_addr];

    always_comb begin
        din    = (dp_round == 4'd1) ? {dp_d, dp_c, dp_b, dp_a} : fb;
        dp_out = aes_round(din, {dp_k4, dp_k3, dp_k2, dp_k1}, dp_round == 4'd10);
    end
    assign {dp_w, dp_z, dp_y, dp_x} = dp_out;

    always @(posedge clk) if (dp_key_flag) fb <= dp_out;

    task automatic load_key(input logic [127:0] key);
        logic [1407:0] sch;
        sch = expand(key);
        for (int i = 0; i < 64; i++) kmem[i] = (i < 44) ? sch[32*i +: 32] : $urandom;
    endtask

    task automatic run_op(input logic [127:0] pt, input bit noise, output int done_cyc);
        addr_q.delete();
        rnd_q.delete();
        busy_cnt = 0;
        done_cyc = -1;
        whiten_s = '0;
        @(negedge clk);
        {pt3, pt2, pt1, pt0} = pt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        {pt3, pt2, pt1, pt0} = rand128();
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (key_rd) addr_q.push_back(key_addr);
            if (dp_key_flag) rnd_q.push_back(dp_round);
            if (busy) busy_cnt++;
            if (cyc == 6) whiten_s = {dp_d, dp_c, dp_b, dp_a};
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = noise && cyc >= 2 && cyc <= 55 && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        {pt3, pt2, pt1, pt0} = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, key_rd, dp_key_flag} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, key_rd, dp_key_flag});
        end
        n_checks++;
        if (key_addr !== 6'd0 || dp_round !== 4'd0) begin
            n_fail++; $display("FAIL reset_addr_round: got %0h/%0h want 0/0", key_addr, dp_round);
        end
        n_checks++;
        if ({dp_a, dp_b, dp_c, dp_d, dp_k1, dp_k2, dp_k3, dp_k4} !== '0) begin
            n_fail++; $display("FAIL reset_dp: got %h%h%h%h want 0", dp_a, dp_b, dp_c, dp_d);
        end
        n_checks++;
        if (ct_all !== '0) begin
            n_fail++; $display("FAIL reset_ct: got %h want 0", ct_all);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || key_rd !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy %b key_rd %b want 0 0", busy, key_rd);
        end
    endtask

    task automatic test_fips();
        int  dc;
        bit  ok;
        load_key(FIPS_KEY);
        run_op(FIPS_PT, 1'b0, dc);
        n_checks++;
        if (dc != 67) begin n_fail++; $display("FAIL fips_latency: got %0d want 67", dc); end
        n_checks++;
        if (busy_cnt != 66) begin n_fail++; $display("FAIL fips_busy_cycles: got %0d want 66", busy_cnt); end
        n_checks++;
        if (ct_all !== FIPS_CT) begin n_fail++; $display("FAIL fips_ct: got %h want %h", ct_all, FIPS_CT); end
        n_checks++;
        if (whiten_s[31:0] !== 32'h30201000) begin
            n_fail++; $display("FAIL fips_whiten: got %h want 30201000", whiten_s[31:0]);
        end
        ok = (addr_q.size() == 44);
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 6'(i)) ok = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fips_addr_trace: got %0d reads, want 44 in order 0..43", addr_q.size()); end
        ok = (rnd_q.size() == 10);
        for (int i = 0; i < rnd_q.size(); i++) if (rnd_q[i] !== 4'(i + 1)) ok = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fips_fire_trace: got %0d fires, want 10 with rounds 1..10", rnd_q.size()); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || ct_all !== FIPS_CT) begin
            n_fail++; $display("FAIL fips_done_pulse_hold: done %b ct %h want 0 %h", done, ct_all, FIPS_CT);
        end
    endtask

    task automatic test_random();
        logic [127:0] key, pt, exp;
        int dc;
        for (int t = 0; t < 4; t++) begin
            key = rand128();
            pt  = rand128();
            exp = aes_encrypt(key, pt);
            load_key(key);
            run_op(pt, 1'b1, dc);
            n_checks++;
            if (dc != 67) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want 67", t, dc); end
            n_checks++;
            if (ct_all !== exp) begin n_fail++; $display("FAIL rand%0d_ct: got %h want %h", t, ct_all, exp); end
            n_checks++;
            if (whiten_s !== (pt ^ key)) begin
                n_fail++; $display("FAIL rand%0d_whiten: got %h want %h", t, whiten_s, pt ^ key);
            end
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_no_queue: busy %b want 0", t, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] key, pa, pb, ct_a;
        int dq [$];
        int overlap;
        key = rand128(); pa = rand128(); pb = rand128();
        load_key(key);
        overlap = 0;
        ct_a = '0;
        @(negedge clk);
        {pt3, pt2, pt1, pt0} = pa;
        start = 1'b1;
        @(posedge clk);
        #1 {pt3, pt2, pt1, pt0} = pb;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(negedge clk);
            if (done) begin
                dq.push_back(cyc);
                if (dq.size() == 1) ct_a = ct_all;
            end
            if (done && busy) overlap++;
            if (cyc >= 68) start = 1'b0;
        end
        n_checks++;
        if (!(dq.size() == 2 && dq[0] == 67 && dq[1] == 134)) begin
            n_fail++; $display("FAIL b2b_done_cycles: got %0d pulses, want 2 at 67 and 134", dq.size());
        end
        n_checks++;
        if (ct_a !== aes_encrypt(key, pa)) begin
            n_fail++; $display("FAIL b2b_ct_first: got %h want %h", ct_a, aes_encrypt(key, pa));
        end
        n_checks++;
        if (ct_all !== aes_encrypt(key, pb)) begin
            n_fail++; $display("FAIL b2b_ct_second: got %h want %h", ct_all, aes_encrypt(key, pb));
        end
        n_checks++;
        if (overlap != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_overlap: overlap %0d busy %b want 0 0", overlap, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] key, pt;
        int dc, dcount;
        key = rand128(); pt = rand128();
        load_key(key);
        dcount = 0;
        @(negedge clk);
        {pt3, pt2, pt1, pt0} = rand128();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, key_rd, dp_key_flag} !== 4'b0000 || dcount != 0) begin
            n_fail++; $display("FAIL midreset_ctrl: got %b done_seen %0d want 0000 0", {busy, done, key_rd, dp_key_flag}, dcount);
        end
        n_checks++;
        if (key_addr !== 6'd0 || dp_round !== 4'd0 || {dp_a, dp_k1, dp_k4} !== '0 || ct_all !== '0) begin
            n_fail++; $display("FAIL midreset_data: addr %0h round %0h ct %h want all 0", key_addr, dp_round, ct_all);
        end
        @(negedge clk) rst_n = 1'b1;
        run_op(pt, 1'b0, dc);
        n_checks++;
        if (dc != 67 || ct_all !== aes_encrypt(key, pt)) begin
            n_fail++; $display("FAIL midreset_rerun: cycle %0d ct %h want 67 %h", dc, ct_all, aes_encrypt(key, pt));
        end
    endtask

`ifdef AES_SEQ_ABORT_EN
    task automatic test_abort();
        logic [127:0] key, pt, ct_before;
        int dc, dcount;
        ct_before = ct_all;
        key = rand128(); pt = rand128();
        load_key(key);
        dcount = 0;
        @(negedge clk);
        {pt3, pt2, pt1, pt0} = rand128();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            @(negedge clk);
            if (done) dcount++;
            if (cyc == 20) abort = 1'b1;
            if (cyc == 21) begin
                abort = 1'b0;
                n_checks++;
                if ({busy, key_rd, dp_key_flag} !== 3'b000) begin
                    n_fail++; $display("FAIL abort_idle: got %b want 000", {busy, key_rd, dp_key_flag});
                end
            end
        end
        n_checks++;
        if (dcount != 0 || ct_all !== ct_before) begin
            n_fail++; $display("FAIL abort_no_done: pulses %0d ct %h want 0 %h", dcount, ct_all, ct_before);
        end
        run_op(pt, 1'b0, dc);
        n_checks++;
        if (dc != 67 || ct_all !== aes_encrypt(key, pt)) begin
            n_fail++; $display("FAIL abort_rerun: cycle %0d ct %h want 67 %h", dc, ct_all, aes_encrypt(key, pt));
        end
    endtask
`endif

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_SEQ_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
